// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two-requester front end for a byte-wide UART transmitter.
// Each grant sends one 16-bit frame as two bytes, high byte first. A per-byte
// timer aborts the frame if the transmitter never reports done, and ties
// between requesters are broken in favour of whoever was not served last.
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 60000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [15:0] data0,
  input  logic        req1,
  input  logic [15:0] data1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        busy,
  output logic        owner
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START0,
    WAIT0,
    START1,
    WAIT1,
    FINISH
  } state_t;

  state_t             r_state;
  logic [15:0]        r_buffer;
  logic [TIMER_W-1:0] r_timer;
  logic               r_owner;
  logic               r_lastGrant;
  logic               r_busy;
  logic               r_txStart;
  logic [7:0]         r_txData;
  logic               r_ack0;
  logic               r_ack1;
  logic               r_err0;
  logic               r_err1;

  logic               w_anyReq;
  logic               w_grantSel;
  logic [15:0]        w_grantData;
  logic               w_timerLast;

  // Choose the winner: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    w_anyReq    = req0 | req1;
    w_grantSel  = (req0 && req1) ? ~r_lastGrant : req1;
    w_grantData = w_grantSel ? data1 : data0;
    w_timerLast = (r_timer == TIMER_LAST);
  end

  // Frame sequencer: grant, two start/wait byte phases, then a one-cycle result pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_buffer    <= '0;
      r_timer     <= '0;
      r_owner     <= 1'b0;
      r_lastGrant <= 1'b1;
      r_busy      <= 1'b0;
      r_txStart   <= 1'b0;
      r_txData    <= '0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
    end else begin
      r_txStart <= 1'b0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_err0    <= 1'b0;
      r_err1    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_owner   <= w_grantSel;
            r_buffer  <= w_grantData;
            r_busy    <= 1'b1;
            r_txStart <= 1'b1;
            r_txData  <= w_grantData[15:8];
            r_timer   <= '0;
            r_state   <= START0;
          end
        end
        START0: begin
          r_timer <= '0;
          r_state <= WAIT0;
        end
        WAIT0: begin
          if (tx_done) begin
            r_txStart <= 1'b1;
            r_txData  <= r_buffer[7:0];
            r_timer   <= '0;
            r_state   <= START1;
          end else if (w_timerLast) begin
            r_err0  <= ~r_owner;
            r_err1  <= r_owner;
            r_state <= FINISH;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        START1: begin
          r_timer <= '0;
          r_state <= WAIT1;
        end
        WAIT1: begin
          if (tx_done) begin
            r_ack0  <= ~r_owner;
            r_ack1  <= r_owner;
            r_state <= FINISH;
          end else if (w_timerLast) begin
            r_err0  <= ~r_owner;
            r_err1  <= r_owner;
            r_state <= FINISH;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        FINISH: begin
          r_lastGrant <= r_owner;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign err0     = r_err0;
  assign err1     = r_err1;
  assign tx_start = r_txStart;
  assign tx_data  = r_txData;
  assign busy     = r_busy;
  assign owner    = r_owner;

endmodule
